// File: rtl/init_sequencer.sv
// init_sequencer: power-on / soft-reset sequencer for the CNN datapath.
// Holds the buffer controller in reset, sweeps zeros over every buffer word,
// waits a guard gap, then releases the core and raises init_done.
module init_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_rst_req,
  input  logic                  clr_stall,
  output logic                  mem_rst,
  output logic                  core_rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_data,
  output logic                  init_done
);

  // One counter serves both HOLD and GAP; it only needs to reach max-1.
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    mem_rst_nxt;
  logic                    core_rst_nxt;
  logic                    init_done_nxt;
  logic [ADDR_WIDTH-1:0]   clr_addr_nxt;

  // The buffer replicates this lane across the word, so a constant zero suffices.
  assign clr_data = 1'b0;

  // State and registered outputs; rst forces the start-of-sequence values at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      mem_rst   <= 1'b1;
      core_rst  <= 1'b1;
      clr_addr  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_rst   <= mem_rst_nxt;
      core_rst  <= core_rst_nxt;
      clr_addr  <= clr_addr_nxt;
      init_done <= init_done_nxt;
    end
  end

  // Next-state logic; clr_we reacts to clr_stall in the same cycle.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    mem_rst_nxt   = mem_rst;
    core_rst_nxt  = core_rst;
    init_done_nxt = init_done;
    clr_addr_nxt  = clr_addr;
    clr_we        = (state == ST_CLEAR) && !clr_stall;

    case (state)
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt   = ST_CLEAR;
          mem_rst_nxt = 1'b0;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_CLEAR: begin
        // A stalled cycle issues no write, so the address simply holds.
        if (clr_we) begin
          if (clr_addr == ADDR_LAST) begin
            state_nxt    = ST_GAP;
            clr_addr_nxt = '0;
            cnt_nxt      = '0;
          end else begin
            clr_addr_nxt = clr_addr + ADDR_WIDTH'(1);
          end
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt     = ST_DONE;
          core_rst_nxt  = 1'b0;
          init_done_nxt = 1'b1;
          cnt_nxt       = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // Re-init is honoured only here; requests earlier in the sequence are dropped.
        if (soft_rst_req) begin
          state_nxt     = ST_HOLD;
          cnt_nxt       = '0;
          mem_rst_nxt   = 1'b1;
          core_rst_nxt  = 1'b1;
          init_done_nxt = 1'b0;
          clr_addr_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_init_sequencer.sv
// Testbench for init_sequencer: default-parameter instance plus a minimal
// HOLD=1/DEPTH=1/GAP=1 instance, checked against edge numbers derived from
// the sequence timing and a queue of expected clear addresses.
module tb_init_sequencer;

  logic       clk;
  logic       rst;
  logic       soft_rst_req;
  logic       clr_stall;
  logic       mem_rst;
  logic       core_rst;
  logic       clr_we;
  logic [7:0] clr_addr;
  logic       clr_data;
  logic       init_done;

  logic       s_rst;
  logic       s_soft;
  logic       s_stall;
  logic       s_mem_rst;
  logic       s_core_rst;
  logic       s_clr_we;
  logic [0:0] s_clr_addr;
  logic       s_clr_data;
  logic       s_init_done;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int exp_q[$];

  init_sequencer #(
    .HOLD_CYCLES(16), .ADDR_WIDTH(8), .DEPTH(256), .GAP_CYCLES(4)
  ) u_dut (
    .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req), .clr_stall(clr_stall),
    .mem_rst(mem_rst), .core_rst(core_rst), .clr_we(clr_we),
    .clr_addr(clr_addr), .clr_data(clr_data), .init_done(init_done)
  );

  init_sequencer #(
    .HOLD_CYCLES(1), .ADDR_WIDTH(1), .DEPTH(1), .GAP_CYCLES(1)
  ) u_small (
    .clk(clk), .rst(s_rst), .soft_rst_req(s_soft), .clr_stall(s_stall),
    .mem_rst(s_mem_rst), .core_rst(s_core_rst), .clr_we(s_clr_we),
    .clr_addr(s_clr_addr), .clr_data(s_clr_data), .init_done(s_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_rst"},   32'(mem_rst),   1);
    check({tag, "_core_rst"},  32'(core_rst),  1);
    check({tag, "_clr_addr"},  32'(clr_addr),  0);
    check({tag, "_init_done"}, 32'(init_done), 0);
    check({tag, "_clr_we"},    32'(clr_we),    0);
  endtask

  // Restart the default DUT with a clean reset; edge numbering restarts at 0.
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    edge_n = 0;
  endtask

  // Run one sequence until init_done, scoreboarding every clear write.
  task automatic run_seq(input int budget, input int stall_addr, input int stall_len,
                         input int s0, input int s1, input int s2,
                         output int mem_fall, output int first_wr, output int last_wr,
                         output int n_wr, output int done_edge);
    int start;
    int stall_left;
    int e;
    int exp_addr;
    bit stall_used;
    start = edge_n;
    stall_left = 0;
    stall_used = 1'b0;
    mem_fall = -1;
    first_wr = -1;
    last_wr = -1;
    n_wr = 0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(i);
    while (!init_done && (edge_n - start) < budget) begin
      e = edge_n + 1;
      soft_rst_req = (e == s0) || (e == s1) || (e == s2);
      if (stall_len > 0 && !stall_used && stall_left == 0 && !mem_rst && core_rst &&
          int'(clr_addr) == stall_addr) begin
        stall_left = stall_len;
        stall_used = 1'b1;
      end
      clr_stall = (stall_left > 0);
      #1;
      if (clr_stall) begin
        check("stall_we", 32'(clr_we), 0);
        check("stall_addr", 32'(clr_addr), 32'(stall_addr));
      end
      if (clr_we) begin
        check("we_mem_rst", 32'(mem_rst), 0);
        check("clr_data", 32'(clr_data), 0);
        if (exp_q.size() == 0) begin
          check("extra_write", 32'(clr_addr), 32'hFFFF_FFFF);
        end else begin
          exp_addr = exp_q.pop_front();
          check("wr_addr", 32'(clr_addr), 32'(exp_addr));
        end
        n_wr++;
        if (first_wr < 0) first_wr = e;
        last_wr = e;
      end
      @(posedge clk);
      #1;
      edge_n++;
      if (stall_left > 0) stall_left--;
      if (mem_fall < 0 && !mem_rst) mem_fall = edge_n;
      if (!core_rst) begin
        check("inv_mem_rst", 32'(mem_rst), 0);
        check("inv_init_done", 32'(init_done), 1);
      end
    end
    soft_rst_req = 1'b0;
    clr_stall = 1'b0;
    done_edge = init_done ? edge_n : -1;
    check("all_addrs_written", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int mf, fw, lw, nw, de;
    int s_mf, s_wr_edge, s_wr_cnt, s_done;
    rst = 1'b1;
    soft_rst_req = 1'b0;
    clr_stall = 1'b0;
    s_rst = 1'b1;
    s_soft = 1'b0;
    s_stall = 1'b0;

    // Reset state
    step();
    step();
    check_reset_vals("rst");
    check("rst_clr_data", 32'(clr_data), 0);

    // Default parameters, no stall
    rst = 1'b0;
    edge_n = 0;
    run_seq(400, -1, 0, 0, 0, 0, mf, fw, lw, nw, de);
    check("A_mem_fall", 32'(mf), 16);
    check("A_first_wr", 32'(fw), 17);
    check("A_last_wr", 32'(lw), 272);
    check("A_n_wr", 32'(nw), 256);
    check("A_done", 32'(de), 276);
    check("A_core_rst", 32'(core_rst), 0);

    // DONE holds its outputs until the soft request
    while (edge_n < 299) step();
    check("A_hold_mem_rst", 32'(mem_rst), 0);
    check("A_hold_core_rst", 32'(core_rst), 0);
    check("A_hold_init_done", 32'(init_done), 1);
    check("A_hold_clr_addr", 32'(clr_addr), 0);
    check("A_hold_clr_we", 32'(clr_we), 0);

    // Soft re-init sampled at edge 300
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    check("soft_mem_rst", 32'(mem_rst), 1);
    check("soft_core_rst", 32'(core_rst), 1);
    check("soft_init_done", 32'(init_done), 0);
    run_seq(400, -1, 0, 0, 0, 0, mf, fw, lw, nw, de);
    check("soft_mem_fall", 32'(mf), 316);
    check("soft_n_wr", 32'(nw), 256);
    check("soft_done", 32'(de), 576);

    // Five-cycle stall at address 100
    do_reset();
    run_seq(400, 100, 5, 0, 0, 0, mf, fw, lw, nw, de);
    check("B_first_wr", 32'(fw), 17);
    check("B_last_wr", 32'(lw), 277);
    check("B_n_wr", 32'(nw), 256);
    check("B_done", 32'(de), 281);

    // Asynchronous reset in the middle of CLEAR
    do_reset();
    while (!(int'(clr_addr) == 57 && !mem_rst) && edge_n < 200) step();
    check("C_reached_57", 32'(clr_addr), 57);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("C_async");
    step();
    step();
    rst = 1'b0;
    edge_n = 0;
    run_seq(400, -1, 0, 0, 0, 0, mf, fw, lw, nw, de);
    check("C_n_wr", 32'(nw), 256);
    check("C_done", 32'(de), 276);

    // Soft requests in HOLD, CLEAR and GAP are ignored
    do_reset();
    run_seq(400, -1, 0, 5, 100, 274, mf, fw, lw, nw, de);
    check("D_mem_fall", 32'(mf), 16);
    check("D_n_wr", 32'(nw), 256);
    check("D_done", 32'(de), 276);

    // Minimal instance: HOLD=1, DEPTH=1, GAP=1
    check("E_rst_mem_rst", 32'(s_mem_rst), 1);
    check("E_rst_init_done", 32'(s_init_done), 0);
    check("E_rst_clr_data", 32'(s_clr_data), 0);
    s_rst = 1'b0;
    s_mf = -1;
    s_wr_edge = -1;
    s_wr_cnt = 0;
    s_done = -1;
    for (int k = 1; k <= 10 && s_done < 0; k++) begin
      if (s_clr_we) begin
        check("E_wr_addr", 32'(s_clr_addr), 0);
        check("E_wr_mem_rst", 32'(s_mem_rst), 0);
        s_wr_edge = k;
        s_wr_cnt++;
      end
      @(posedge clk);
      #1;
      if (s_mf < 0 && !s_mem_rst) s_mf = k;
      if (s_init_done) s_done = k;
    end
    check("E_mem_fall", 32'(s_mf), 1);
    check("E_wr_edge", 32'(s_wr_edge), 2);
    check("E_wr_cnt", 32'(s_wr_cnt), 1);
    check("E_done", 32'(s_done), 3);
    check("E_core_rst", 32'(s_core_rst), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
